// File: rtl/data_sync_tx.sv
// Transmit-side launcher for the multi-flop data synchronizer: holds a word on UNSYNC_bus and strobes bus_enable.
// Define DATA_SYNC_TX_ACK_EN for a four-phase ack handshake; otherwise the enable is a timed HOLD/GAP pulse.
module data_sync_tx #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 src_valid,
    input  logic [BUS_WIDTH-1:0] src_data,
    output logic                 src_ready,
    input  logic                 ack,
    output logic [BUS_WIDTH-1:0] UNSYNC_bus,
    output logic                 bus_enable,
    output logic                 busy
);

    // state | meaning
    // IDLE  | ready for a new word, previous word still on the bus
    // SETUP | word launched, one settle cycle before enable
    // HOLD  | bus_enable high
    // GAP   | bus_enable low, word still held
    typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

    state_t state;
    logic   hold_done;
    logic   gap_done;

    assign src_ready = (state == IDLE);
    assign busy      = ~src_ready;

`ifdef DATA_SYNC_TX_ACK_EN
    logic [NUM_STAGES-1:0] ack_sync_q;
    logic                  ack_sync;
    logic                  unused_cfg;

    assign unused_cfg = HOLD_CYCLES[0] ^ GAP_CYCLES[0];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], ack};
        end
    end

    assign ack_sync  = ack_sync_q[NUM_STAGES-1];
    assign hold_done = ack_sync;
    assign gap_done  = ~ack_sync;
`else
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          unused_ack;

    assign unused_ack = ack ^ NUM_STAGES[0];
    assign hold_done  = (cnt == HOLD_LAST);
    assign gap_done   = (cnt == GAP_LAST);

    // Counter returns to zero on the cycle it terminates, so every state entry starts from zero.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
        end else if ((state == HOLD && !hold_done) || (state == GAP && !gap_done)) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            UNSYNC_bus <= '0;
            bus_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (src_valid) begin
                        UNSYNC_bus <= src_data;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    bus_enable <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (hold_done) begin
                        bus_enable <= 1'b0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus_enable <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx; exercises the timed build by default and the ack build when DATA_SYNC_TX_ACK_EN is defined.
module tb_data_sync_tx;

    localparam int HOLD = 8;
    localparam int GAP  = 8;

    logic       CLK;
    logic       RST_n;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       ack;
    logic [7:0] UNSYNC_bus;
    logic       bus_enable;
    logic       busy;

    logic       src_valid2;
    logic [0:0] src_data2;
    logic       src_ready2;
    logic       ack2;
    logic [0:0] UNSYNC_bus2;
    logic       bus_enable2;
    logic       busy2;

    int total = 0;
    int bad   = 0;

    data_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST_n(RST_n), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .ack(ack), .UNSYNC_bus(UNSYNC_bus),
        .bus_enable(bus_enable), .busy(busy)
    );

    data_sync_tx #(.BUS_WIDTH(1), .NUM_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut2 (
        .CLK(CLK), .RST_n(RST_n), .src_valid(src_valid2), .src_data(src_data2),
        .src_ready(src_ready2), .ack(ack2), .UNSYNC_bus(UNSYNC_bus2),
        .bus_enable(bus_enable2), .busy(busy2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       ready_m;
        int         cnt_m;
        int         accepts;
        logic [7:0] exp_bus;
        logic [7:0] d;

        RST_n = 1'b1; src_valid = 1'b0; src_data = '0; ack = 1'b0;
        src_valid2 = 1'b0; src_data2 = '0; ack2 = 1'b0;
        #1 RST_n = 1'b0;
        #1;
        chk("rst_ready", 32'(src_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'(bus_enable), 0);
        chk("rst_bus", 32'(UNSYNC_bus), 0);
        tick(2);
        chk("rst_ready_clk", 32'(src_ready), 1);
        RST_n = 1'b1;
        tick(1);

`ifndef DATA_SYNC_TX_ACK_EN
        // single timed send
        src_valid = 1'b1; src_data = 8'hA5;
        tick(1);
        src_valid = 1'b0; src_data = 8'h00;
        chk("t1_bus", 32'(UNSYNC_bus), 'hA5);
        chk("t1_en0", 32'(bus_enable), 0);
        chk("t1_busy", 32'(busy), 1);
        for (int j = 1; j <= HOLD + GAP + 1; j++) begin
            tick(1);
            chk("t1_en", 32'(bus_enable), 32'((j <= HOLD) ? 1 : 0));
            chk("t1_ready", 32'(src_ready), 32'((j == HOLD + GAP + 1) ? 1 : 0));
        end
        chk("t1_bus_hold", 32'(UNSYNC_bus), 'hA5);

        // continuous offer with changing data
        ready_m = 1'b1; cnt_m = 0; accepts = 0; exp_bus = 8'hA5; d = 8'h01;
        src_valid = 1'b1; src_data = d;
        for (int i = 0; i < 3 * (HOLD + GAP + 2); i++) begin
            tick(1);
            if (ready_m) begin
                exp_bus = d; ready_m = 1'b0; cnt_m = 0; accepts++;
            end else begin
                cnt_m++;
                if (cnt_m == HOLD + GAP + 1) ready_m = 1'b1;
            end
            chk("s_bus", 32'(UNSYNC_bus), 32'(exp_bus));
            chk("s_ready", 32'(src_ready), 32'(ready_m));
            chk("s_en", 32'(bus_enable), 32'((!ready_m && cnt_m >= 1 && cnt_m <= HOLD) ? 1 : 0));
            d = d + 8'h01;
            src_data = d;
        end
        src_valid = 1'b0;
        chk("s_accepts", 32'(accepts), 3);
        chk("s_last_word", 32'(exp_bus), 'h25);

        // minimal configuration instance
        src_valid2 = 1'b1; src_data2 = 1'b1;
        tick(1);
        src_valid2 = 1'b0; src_data2 = 1'b0;
        chk("m_bus", 32'(UNSYNC_bus2), 1);
        chk("m_en0", 32'(bus_enable2), 0);
        chk("m_ready0", 32'(src_ready2), 0);
        tick(1);
        chk("m_en1", 32'(bus_enable2), 1);
        tick(1);
        chk("m_en2", 32'(bus_enable2), 0);
        chk("m_ready2", 32'(src_ready2), 0);
        tick(1);
        chk("m_ready3", 32'(src_ready2), 1);
        chk("m_bus_hold", 32'(UNSYNC_bus2), 1);
`endif

        // asynchronous reset during HOLD
        src_valid = 1'b1; src_data = 8'h77;
        tick(1);
        src_valid = 1'b0;
        tick(4);
        chk("r_en_pre", 32'(bus_enable), 1);
        chk("r_bus_pre", 32'(UNSYNC_bus), 'h77);
        #2 RST_n = 1'b0;
        #1;
        chk("r_en", 32'(bus_enable), 0);
        chk("r_bus", 32'(UNSYNC_bus), 0);
        chk("r_busy", 32'(busy), 0);
        #2 RST_n = 1'b1;
        tick(1);
        src_valid = 1'b1; src_data = 8'h3C;
        tick(1);
        src_valid = 1'b0;
        chk("r2_bus", 32'(UNSYNC_bus), 'h3C);
        chk("r2_en0", 32'(bus_enable), 0);
        tick(1);
        chk("r2_en1", 32'(bus_enable), 1);

`ifdef DATA_SYNC_TX_ACK_EN
        // handshake: ack raised three cycles after enable
        tick(3);
        ack = 1'b1;
        tick(2);
        chk("a_en_hold", 32'(bus_enable), 1);
        tick(1);
        chk("a_en_fall", 32'(bus_enable), 0);
        chk("a_busy", 32'(busy), 1);
        tick(3);
        ack = 1'b0;
        tick(2);
        chk("a_ready_wait", 32'(src_ready), 0);
        tick(1);
        chk("a_ready", 32'(src_ready), 1);

        // ack already high at accept
        ack = 1'b1;
        tick(3);
        src_valid = 1'b1; src_data = 8'h5A;
        tick(1);
        src_valid = 1'b0;
        chk("k_bus", 32'(UNSYNC_bus), 'h5A);
        tick(1);
        chk("k_en1", 32'(bus_enable), 1);
        tick(1);
        chk("k_en0", 32'(bus_enable), 0);
        tick(5);
        chk("k_wait", 32'(busy), 1);
        chk("k_en_wait", 32'(bus_enable), 0);
        ack = 1'b0;
        tick(2);
        chk("k_busy2", 32'(busy), 1);
        tick(1);
        chk("k_ready", 32'(src_ready), 1);
`else
        tick(HOLD + GAP);
        chk("r2_ready", 32'(src_ready), 1);
        chk("r2_bus_hold", 32'(UNSYNC_bus), 'h3C);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
